// File: rtl/lfsr_seq_detector.sv
// Serial pattern detector that sits behind the 16-bit LFSR.
// Shifts in one bit per accepted cycle, flags every (possibly overlapping) match of PATTERN,
// and counts matches over exactly PERIOD accepted bits before freezing the result.
module lfsr_seq_detector #(
  parameter int unsigned              PAT_LEN = 8,
  parameter logic [PAT_LEN-1:0]       PATTERN = 8'b10110011,
  parameter int unsigned              CNT_W   = 21,
  parameter int unsigned              PERIOD  = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             seq_detected,
  output logic [CNT_W-1:0] detect_counter,
  output logic [16:0]      bits_seen,
  output logic             done
);

  // Wide enough to hold the value PAT_LEN itself (fill saturates there).
  localparam int unsigned FillW = $clog2(PAT_LEN + 1);

  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);
  localparam logic [16:0]      BitsEnd  = 17'(PERIOD);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] window_q, window_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [16:0]        bits_q, bits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seq_q, seq_d;

  logic accept;
  logic match;
  logic period_end;

  // Acceptance and match qualification on the post-shift window.
  always_comb begin
    accept     = bit_valid && (state_q != StDone) && !clear;
    window_d   = window_q;
    fill_d     = fill_q;
    bits_d     = bits_q;
    match      = 1'b0;
    period_end = 1'b0;
    if (accept) begin
      window_d   = {window_q[PAT_LEN-2:0], bit_in};
      fill_d     = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
      bits_d     = bits_q + 1'b1;
      match      = (fill_d == FillFull) && (window_d == PATTERN);
      period_end = (bits_d == BitsEnd);
    end
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
      bits_d   = '0;
    end
  end

  // Next-state, match pulse and saturating counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = 1'b0;
    if (match) begin
      seq_d = 1'b1;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = period_end ? StDone : StFill;
        end
      end
      StFill: begin
        if (accept) begin
          if (period_end) begin
            state_d = StDone;
          end else if (fill_d == FillFull) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept && period_end) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A synchronous restart overrides everything, including a bit arriving the same cycle.
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      seq_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      window_q <= '0;
      fill_q   <= '0;
      bits_q   <= '0;
      cnt_q    <= '0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
    end
  end

  assign seq_detected   = seq_q;
  assign detect_counter = cnt_q;
  assign bits_seen      = bits_q;
  assign done           = (state_q == StDone);

endmodule

// File: tb/tb_lfsr_seq_detector.sv
// Directed bench for lfsr_seq_detector: four instances with different parameter sets share
// one stimulus stream; each scenario restarts them with clear and checks the relevant one.
module tb_lfsr_seq_detector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clear = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // a: default, b: pattern AA, c: period 20, d: 2-bit pattern with 2-bit counter
  logic        seq_a, seq_b, seq_c, seq_d;
  logic [20:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  cnt_d;
  logic [16:0] bits_a, bits_b, bits_c, bits_d;
  logic        done_a, done_b, done_c, done_d;

  int unsigned pulses_a = 0, pulses_b = 0, pulses_c = 0, pulses_d = 0;

  always #5 clk = ~clk;

  lfsr_seq_detector u_a (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .seq_detected(seq_a), .detect_counter(cnt_a), .bits_seen(bits_a), .done(done_a)
  );

  lfsr_seq_detector #(.PATTERN(8'hAA)) u_b (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .seq_detected(seq_b), .detect_counter(cnt_b), .bits_seen(bits_b), .done(done_b)
  );

  lfsr_seq_detector #(.PERIOD(20)) u_c (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .seq_detected(seq_c), .detect_counter(cnt_c), .bits_seen(bits_c), .done(done_c)
  );

  lfsr_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .seq_detected(seq_d), .detect_counter(cnt_d), .bits_seen(bits_d), .done(done_d)
  );

  // Pulse counters sampled mid-cycle; a one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (seq_a) pulses_a <= pulses_a + 1;
    if (seq_b) pulses_b <= pulses_b + 1;
    if (seq_c) pulses_c <= pulses_c + 1;
    if (seq_d) pulses_d <= pulses_d + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) feed(v[i]);
  endtask

  task automatic restart();
    bit_valid = 1'b0;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  int unsigned p0;
  logic [9:0] alt;

  initial begin
    // Reset held while the bit stream toggles.
    reset = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_in = i[0];
      @(posedge clk);
      #1;
    end
    check("rst_seq", 32'(seq_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_bits", 32'(bits_a), 0);
    check("rst_done", 32'(done_a), 0);
    bit_valid = 1'b0;
    reset = 1'b0;
    p0 = pulses_a;
    idle();
    idle();
    check("rel_bits", 32'(bits_a), 0);
    check("rel_pulses", pulses_a - p0, 0);

    // Single match of B3.
    restart();
    p0 = pulses_a;
    feed_byte(8'b1011_0011);
    check("single_seq", 32'(seq_a), 1);
    check("single_pre_pulses", pulses_a - p0, 0);
    idle();
    check("single_seq_drop", 32'(seq_a), 0);
    check("single_pulses", pulses_a - p0, 1);
    check("single_cnt", 32'(cnt_a), 1);
    check("single_bits", 32'(bits_a), 8);

    // Overlapping matches of AA over 1010101010.
    alt = 10'b10_1010_1010;
    restart();
    p0 = pulses_b;
    for (int i = 9; i >= 0; i--) begin
      feed(alt[i]);
      if (i == 2) check("ovl_seq8", 32'(seq_b), 1);
      if (i == 1) check("ovl_seq9", 32'(seq_b), 0);
      if (i == 0) check("ovl_seq10", 32'(seq_b), 1);
    end
    idle();
    check("ovl_cnt", 32'(cnt_b), 2);
    check("ovl_pulses", pulses_b - p0, 2);

    // Same stream with a 3-cycle gap before bit 10.
    restart();
    p0 = pulses_b;
    for (int i = 9; i >= 1; i--) feed(alt[i]);
    for (int i = 0; i < 3; i++) idle();
    check("gap_cnt_mid", 32'(cnt_b), 1);
    check("gap_bits_mid", 32'(bits_b), 9);
    feed(alt[0]);
    check("gap_seq10", 32'(seq_b), 1);
    idle();
    check("gap_cnt", 32'(cnt_b), 2);
    check("gap_pulses", pulses_b - p0, 2);

    // Period end at 20 bits: twelve zeros then B3, match lands on bit 20.
    restart();
    p0 = pulses_c;
    for (int i = 0; i < 11; i++) feed(1'b0);
    feed(1'b0);
    for (int i = 7; i >= 1; i--) feed(8'hB3 >> i);
    check("per_done19", 32'(done_c), 0);
    feed(1'b1);
    check("per_seq20", 32'(seq_c), 1);
    check("per_done20", 32'(done_c), 1);
    check("per_bits20", 32'(bits_c), 20);
    for (int i = 0; i < 5; i++) feed(i[0] ^ 1'b1);
    idle();
    check("per_cnt", 32'(cnt_c), 1);
    check("per_bits_hold", 32'(bits_c), 20);
    check("per_done_hold", 32'(done_c), 1);
    check("per_pulses", pulses_c - p0, 1);

    // Counter saturation with a 2-bit counter: five matches over six ones.
    restart();
    p0 = pulses_d;
    for (int i = 0; i < 6; i++) feed(1'b1);
    check("sat_seq", 32'(seq_d), 1);
    idle();
    check("sat_cnt", 32'(cnt_d), 3);
    check("sat_pulses", pulses_d - p0, 5);

    // Clear beats a valid bit mid-run with counter at 5.
    restart();
    for (int i = 0; i < 5; i++) feed_byte(8'hB3);
    check("clr_cnt_pre", 32'(cnt_a), 5);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_cnt", 32'(cnt_a), 0);
    check("clr_bits", 32'(bits_a), 0);
    check("clr_seq", 32'(seq_a), 0);
    idle();
    check("clr_bits_idle", 32'(bits_a), 0);
    feed(1'b1);
    check("clr_bits_one", 32'(bits_a), 1);

    // Async reset between edges while a pulse is up.
    restart();
    feed_byte(8'hB3);
    check("ares_seq_pre", 32'(seq_a), 1);
    #2;
    reset = 1'b1;
    #1;
    check("ares_seq", 32'(seq_a), 0);
    check("ares_cnt", 32'(cnt_a), 0);
    check("ares_bits", 32'(bits_a), 0);
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
